// File: rtl/seven_seg_scanner.sv
// Scans seven captured digit codes onto a shared active-low 7-segment bus with a blanking gap.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zeros (digits 6..1) at capture.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    input  logic [3:0] digitIn0,
    input  logic [3:0] digitIn1,
    input  logic [3:0] digitIn2,
    input  logic [3:0] digitIn3,
    input  logic [3:0] digitIn4,
    input  logic [3:0] digitIn5,
    input  logic [3:0] digitIn6,
    output logic [6:0] anodeN,
    output logic [6:0] segN,
    output logic       frameStart
);

    localparam int unsigned MAX_COUNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        idx, idx_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [6:0][3:0]   shadow, shadow_nxt, raw, captured;
    logic              capture;
    logic [6:0]        anode_nxt, seg_nxt;

    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            4'd10:   decode = 7'h3F;
            default: decode = 7'h7F;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic suppress;
`endif

    always_comb begin
        raw      = {digitIn6, digitIn5, digitIn4, digitIn3, digitIn2, digitIn1, digitIn0};
        captured = raw;
`ifdef LEADING_ZERO_BLANK_EN
        // Walk from the most significant digit; only a real 1..9 ends suppression.
        suppress = 1'b1;
        for (int unsigned i = 6; i >= 1; i--) begin
            if (suppress && raw[i] == 4'd0)
                captured[i] = 4'hF;
            else if (raw[i] >= 4'd1 && raw[i] <= 4'd9)
                suppress = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '1;
            anodeN     <= '1;
            segN       <= '1;
            frameStart <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            shadow     <= shadow_nxt;
            anodeN     <= anode_nxt;
            segN       <= seg_nxt;
            frameStart <= capture;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + 1'b1;
        capture   = 1'b0;
        if (!enable) begin
            state_nxt = BLANK;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                BLANK: if (cnt == BLANK_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DRIVE;
                    capture   = (idx == 3'd0);
                end
                DRIVE: if (cnt == DRIVE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = BLANK;
                    idx_nxt   = (idx == 3'd6) ? 3'd0 : idx + 3'd1;
                end
                default: state_nxt = BLANK;
            endcase
        end
        shadow_nxt = capture ? captured : shadow;
    end

    // Outputs are derived from the next state so anode and segments switch on the same edge.
    always_comb begin
        anode_nxt = '1;
        seg_nxt   = '1;
        if (state_nxt == DRIVE) begin
            anode_nxt = ~(7'b1 << idx_nxt);
            seg_nxt   = decode(shadow_nxt[idx_nxt]);
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, BLANK_CYCLES=2 (frame = 42 cycles).
module tb_seven_seg_scanner;

    logic       clk = 1'b0;
    logic       resetN;
    logic       enable;
    logic [3:0] d0, d1, d2, d3, d4, d5, d6;
    logic [6:0] anodeN, segN;
    logic       frameStart;

    int unsigned errors = 0;
    int unsigned checks = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LZ = 4'hF;
`else
    localparam logic [3:0] LZ = 4'h0;
`endif

    seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .resetN(resetN), .enable(enable),
        .digitIn0(d0), .digitIn1(d1), .digitIn2(d2), .digitIn3(d3),
        .digitIn4(d4), .digitIn5(d5), .digitIn6(d6),
        .anodeN(anodeN), .segN(segN), .frameStart(frameStart)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] code);
        case (code)
            4'd0: seg_of = 7'h40;  4'd1: seg_of = 7'h79;  4'd2: seg_of = 7'h24;
            4'd3: seg_of = 7'h30;  4'd4: seg_of = 7'h19;  4'd5: seg_of = 7'h12;
            4'd6: seg_of = 7'h02;  4'd7: seg_of = 7'h78;  4'd8: seg_of = 7'h00;
            4'd9: seg_of = 7'h10;  4'd10: seg_of = 7'h3F;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    task automatic check_now(input logic [6:0] ea, input logic [6:0] es, input logic ef, input string tag);
        checks++;
        assert (anodeN === ea) else begin
            errors++;
            $error("FAIL %s anodeN: got %h expected %h", tag, anodeN, ea);
        end
        checks++;
        assert (segN === es) else begin
            errors++;
            $error("FAIL %s segN: got %h expected %h", tag, segN, es);
        end
        checks++;
        assert (frameStart === ef) else begin
            errors++;
            $error("FAIL %s frameStart: got %b expected %b", tag, frameStart, ef);
        end
    endtask

    task automatic step(input logic [6:0] ea, input logic [6:0] es, input logic ef, input string tag);
        @(negedge clk);
        check_now(ea, es, ef, tag);
    endtask

    // Four drive cycles of digit i followed by the two blanking cycles.
    task automatic check_digit(input int unsigned i, input logic [3:0] code, input logic first);
        logic [6:0] an;
        an = ~(7'b1 << i);
        for (int unsigned c = 0; c < 4; c++)
            step(an, seg_of(code), first && (c == 0), $sformatf("drive%0d", i));
        step(7'h7F, 7'h7F, 1'b0, $sformatf("blank%0d", i));
        step(7'h7F, 7'h7F, 1'b0, $sformatf("blank%0d", i));
    endtask

    initial begin
        resetN = 1'b0;
        enable = 1'b1;
        {d6, d5, d4, d3, d2, d1, d0} = {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
        step(7'h7F, 7'h7F, 1'b0, "reset");
        step(7'h7F, 7'h7F, 1'b0, "reset");
        resetN = 1'b1;

        // Frame 1: capture two cycles after reset release
        step(7'h7F, 7'h7F, 1'b0, "startblank");
        check_digit(0, 4'd3, 1'b1);
        check_digit(1, 4'd2, 1'b0);
        check_digit(2, 4'd1, 1'b0);
        d0 = 4'd8; d1 = 4'd9; d3 = 4'd10; d6 = 4'hC;
        check_digit(3, LZ, 1'b0);
        check_digit(4, LZ, 1'b0);
        d1 = 4'd2;
        check_digit(5, LZ, 1'b0);
        check_digit(6, LZ, 1'b0);

        // Frame 2: new captures; inputs changed again after digit 0
        check_digit(0, 4'd8, 1'b1);
        {d6, d5, d4, d3, d2, d1, d0} = {4'd0, 4'd1, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4};
        check_digit(1, 4'd2, 1'b0);
        check_digit(2, 4'd1, 1'b0);
        check_digit(3, 4'd10, 1'b0);
        check_digit(4, LZ, 1'b0);
        check_digit(5, LZ, 1'b0);
        check_digit(6, 4'hC, 1'b0);

        // Frame 3: drop enable partway through digit 4
        check_digit(0, 4'd4, 1'b1);
        check_digit(1, 4'd5, 1'b0);
        check_digit(2, 4'd6, 1'b0);
        check_digit(3, 4'd7, 1'b0);
        step(7'h6F, 7'h10, 1'b0, "drive4");
        step(7'h6F, 7'h10, 1'b0, "drive4");
        enable = 1'b0;
        step(7'h7F, 7'h7F, 1'b0, "disabled");
        step(7'h7F, 7'h7F, 1'b0, "disabled");
        {d6, d5, d4, d3, d2, d1, d0} = {4'd0, 4'd0, 4'd0, 4'd10, 4'd0, 4'd1, 4'd2};
        enable = 1'b1;
        step(7'h7F, 7'h7F, 1'b0, "reenblank");
        check_digit(0, 4'd2, 1'b1);
        check_digit(1, 4'd1, 1'b0);
        check_digit(2, LZ, 1'b0);
        check_digit(3, 4'd10, 1'b0);
        check_digit(4, LZ, 1'b0);
        check_digit(5, LZ, 1'b0);
        check_digit(6, LZ, 1'b0);

        // Asynchronous reset in the middle of a drive cycle
        step(7'h7E, 7'h24, 1'b1, "drive0");
        #1 resetN = 1'b0;
        #1 check_now(7'h7F, 7'h7F, 1'b0, "asyncreset");
        step(7'h7F, 7'h7F, 1'b0, "inreset");
        resetN = 1'b1;
        step(7'h7F, 7'h7F, 1'b0, "postblank");
        check_digit(0, 4'd2, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
